// File: rtl/acc_sched_pkg.sv
// Shared types and constants for the acc_sched job scheduler.
package acc_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int ACC_LAT   = 4;
    localparam int TAG_DEPTH = ACC_LAT + 1;
    localparam int TAG_ID_W  = 3;

    // id is sized for the largest NREQ (8); narrower grants are zero-extended
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/acc_sched_rr_arbiter.sv
// Round-robin arbiter: combinational winner search starting at the pointer,
// pointer moves to one past the winner when the grant is taken.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic            clock,
    input  logic            rstn,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt_oh,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    logic [IDW-1:0] ptr;
    logic           found;
    int             idx;

    assign any = |req;

    always_comb begin
        gnt_oh = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_id      = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (en && any) begin
            if (int'(gnt_id) == NREQ - 1) ptr <= '0;
            else                          ptr <= gnt_id + IDW'(1);
        end
    end

endmodule

// File: rtl/acc_sched.sv
// Job scheduler sharing one pipelined accumulator between NREQ requesters.
// Optional statistics counters are enabled with `define ACC_SCHED_STATS_EN.
module acc_sched
    import acc_sched_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREQ  = 2
) (
    input  logic                    clock,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    input  logic [NREQ-1:0]         req_sub,
    input  logic [NREQ-1:0]         req_last,
    output logic                    acc_clr,
    output logic                    acc_add_sub,
    output logic [WIDTH-1:0]        acc_d,
    input  logic [WIDTH-1:0]        acc_q,
    output logic                    res_valid,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic [WIDTH-1:0]        res_data,
    output logic                    busy
`ifdef ACC_SCHED_STATS_EN
    ,
    output logic [31:0]             stat_jobs,
    output logic [31:0]             stat_beats
`endif
);

    localparam int IDW = $clog2(NREQ);

    // Handshake: a beat transfers on a cycle where req_valid[i] and
    // req_ready[i] are both high; ready never depends on valid.
    state_t            state;
    logic [IDW-1:0]    grant;
    logic [NREQ-1:0]   grant_oh;
    logic              first;
    logic              accept;
    logic              arb_en;
    logic [NREQ-1:0]   win_oh;
    logic [IDW-1:0]    win_id;
    logic              win_any;
    tag_t              tags [TAG_DEPTH];

    assign arb_en    = (state == IDLE);
    assign req_ready = (state == BUSY) ? grant_oh : '0;
    assign accept    = (state == BUSY) && req_valid[grant];

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clock  (clock),
        .rstn   (rstn),
        .req    (req_valid),
        .en     (arb_en),
        .gnt_oh (win_oh),
        .gnt_id (win_id),
        .any    (win_any)
    );

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            grant    <= '0;
            grant_oh <= '0;
            first    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        grant    <= win_id;
                        grant_oh <= win_oh;
                        first    <= 1'b1;
                        state    <= BUSY;
                    end
                end
                default: begin
                    if (accept) begin
                        first <= 1'b0;
                        if (req_last[grant]) state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Idle cycles feed add-zero so the accumulator holds its value.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            acc_clr     <= 1'b0;
            acc_add_sub <= 1'b0;
            acc_d       <= '0;
        end else if (accept) begin
            acc_clr     <= first;
            acc_add_sub <= req_sub[grant];
            acc_d       <= req_data[int'(grant)*WIDTH +: WIDTH];
        end else begin
            acc_clr     <= 1'b0;
            acc_add_sub <= 1'b0;
            acc_d       <= '0;
        end
    end

    // Tag shift matches the accumulator depth plus the output register.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < TAG_DEPTH; i++) tags[i] <= '0;
        end else begin
            tags[0].valid <= accept && req_last[grant];
            tags[0].id    <= TAG_ID_W'(grant);
            for (int i = 1; i < TAG_DEPTH; i++) tags[i] <= tags[i-1];
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
        end else begin
            res_valid <= tags[TAG_DEPTH-1].valid;
            if (tags[TAG_DEPTH-1].valid) begin
                res_id   <= tags[TAG_DEPTH-1].id[IDW-1:0];
                res_data <= acc_q;
            end
        end
    end

    always_comb begin
        busy = (state == BUSY);
        for (int i = 0; i < TAG_DEPTH; i++) busy = busy | tags[i].valid;
    end

`ifdef ACC_SCHED_STATS_EN
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            stat_jobs  <= '0;
            stat_beats <= '0;
        end else begin
            if (res_valid) stat_jobs  <= stat_jobs + 32'd1;
            if (accept)    stat_beats <= stat_beats + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_acc_sched.sv
// Directed bench for acc_sched with a behavioural 4-cycle accumulator model.
module tb_acc_sched;

    localparam int WIDTH = 16;
    localparam int NREQ  = 2;

    logic                 clock;
    logic                 rstn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]      req_sub;
    logic [NREQ-1:0]      req_last;
    logic                 acc_clr;
    logic                 acc_add_sub;
    logic [WIDTH-1:0]     acc_d;
    logic [WIDTH-1:0]     acc_q;
    logic                 res_valid;
    logic [0:0]           res_id;
    logic [WIDTH-1:0]     res_data;
    logic                 busy;
`ifdef ACC_SCHED_STATS_EN
    logic [31:0]          stat_jobs;
    logic [31:0]          stat_beats;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [0:0]       exp_id_q[$];
    logic [WIDTH-1:0] exp_q[$];
    int               exp_cyc_q[$];

    acc_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clock       (clock),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .req_sub     (req_sub),
        .req_last    (req_last),
        .acc_clr     (acc_clr),
        .acc_add_sub (acc_add_sub),
        .acc_d       (acc_d),
        .acc_q       (acc_q),
        .res_valid   (res_valid),
        .res_id      (res_id),
        .res_data    (res_data),
        .busy        (busy)
`ifdef ACC_SCHED_STATS_EN
        ,
        .stat_jobs   (stat_jobs),
        .stat_beats  (stat_beats)
`endif
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Accumulator model: full-width sum one edge after D, then 3 delay stages.
    logic [WIDTH-1:0] m_sum = '0, m_d1 = '0, m_d2 = '0, m_d3 = '0;
    always @(posedge clock) begin
        m_sum <= (acc_clr ? '0 : m_sum) + (acc_add_sub ? (WIDTH'(0) - acc_d) : acc_d);
        m_d1  <= m_sum;
        m_d2  <= m_d1;
        m_d3  <= m_d2;
    end
    assign acc_q = m_d3;

    // scoreboard: every result strobe is matched to the oldest expected job
    always @(negedge clock) begin
        if (res_valid) begin
            n_tests++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_result: id=%0d data=%h, no job outstanding", res_id, res_data);
            end
            if (exp_q.size() != 0) begin
                logic [0:0]       e_id;
                logic [WIDTH-1:0] e_data;
                int               e_cyc;
                e_id   = exp_id_q.pop_front();
                e_data = exp_q.pop_front();
                e_cyc  = exp_cyc_q.pop_front();
                n_tests++;
                assert (res_data === e_data) else begin
                    n_fail++;
                    $error("FAIL res_data: got %h expected %h", res_data, e_data);
                end
                n_tests++;
                assert (res_id === e_id) else begin
                    n_fail++;
                    $error("FAIL res_id: got %0d expected %0d", res_id, e_id);
                end
                n_tests++;
                assert (cyc - e_cyc === 5) else begin
                    n_fail++;
                    $error("FAIL latency: got %0d expected 5", cyc - e_cyc);
                end
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = '0;
        req_sub   = '0;
        req_last  = '0;
        req_data  = '0;
        repeat (3) @(posedge clock);
        #1 rstn = 1'b1;
    endtask

    task automatic send_beat(input int r, input logic [WIDTH-1:0] d, input logic s, input logic l);
        int n;
        req_valid[r]                = 1'b1;
        req_data[r*WIDTH +: WIDTH]  = d;
        req_sub[r]                  = s;
        req_last[r]                 = l;
        n = 0;
        @(negedge clock);
        while (!req_ready[r] && n < 20) begin
            @(negedge clock);
            n++;
        end
        n_tests++;
        assert (req_ready[r] === 1'b1) else begin
            n_fail++;
            $error("FAIL ready_timeout: req %0d ready=%b expected 1", r, req_ready[r]);
        end
        @(posedge clock);
        #1;
        req_valid[r] = 1'b0;
        req_sub[r]   = 1'b0;
        req_last[r]  = 1'b0;
    endtask

    // call right after the accepting edge of a job's last beat
    task automatic job_end(input int r, input logic [WIDTH-1:0] sum);
        exp_id_q.push_back(1'(r));
        exp_q.push_back(sum);
        exp_cyc_q.push_back(cyc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 40) begin
            @(negedge clock);
            n++;
        end
        n_tests++;
        assert (exp_q.size() === 0) else begin
            n_fail++;
            $error("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    int bc[2];
    int jc[2];
    int started;
    int done;
    logic [NREQ-1:0] acc_r;

    initial begin
        do_reset();

        // idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            n_tests++;
            assert ({req_ready, acc_clr, acc_add_sub, acc_d, res_valid, res_id, res_data, busy} === '0) else begin
                n_fail++;
                $error("FAIL reset_idle: rdy=%b clr=%b d=%h rv=%b busy=%b expected all 0",
                       req_ready, acc_clr, acc_d, res_valid, busy);
            end
        end

        // basic job: 0x10 + 0x5 - 0x3 = 0x12
        send_beat(0, 16'h0010, 1'b0, 1'b0);
        n_tests++;
        assert ({acc_clr, acc_add_sub, acc_d} === {1'b1, 1'b0, 16'h0010}) else begin
            n_fail++;
            $error("FAIL first_beat: clr=%b sub=%b d=%h expected 1 0 0010", acc_clr, acc_add_sub, acc_d);
        end
        send_beat(0, 16'h0005, 1'b0, 1'b0);
        n_tests++;
        assert (acc_clr === 1'b0) else begin
            n_fail++;
            $error("FAIL second_clr: got %b expected 0", acc_clr);
        end
        send_beat(0, 16'h0003, 1'b1, 1'b1);
        n_tests++;
        assert ({acc_clr, acc_add_sub, acc_d} === {1'b0, 1'b1, 16'h0003}) else begin
            n_fail++;
            $error("FAIL sub_beat: clr=%b sub=%b d=%h expected 0 1 0003", acc_clr, acc_add_sub, acc_d);
        end
        job_end(0, 16'h0012);
        drain();

        // slice carries
        send_beat(1, 16'h0FFF, 1'b0, 1'b0);
        send_beat(1, 16'h0001, 1'b0, 1'b1);
        job_end(1, 16'h1000);
        send_beat(0, 16'hFFFF, 1'b0, 1'b0);
        send_beat(0, 16'h0001, 1'b0, 1'b1);
        job_end(0, 16'h0000);
        drain();

        // single-beat jobs back to back; clr isolates them
        send_beat(0, 16'h0001, 1'b1, 1'b1);
        job_end(0, 16'hFFFF);
        send_beat(0, 16'h0007, 1'b0, 1'b1);
        job_end(0, 16'h0007);
        drain();

        // both requesters continuously valid from reset: grants alternate 0,1,0,1
        do_reset();
        bc = '{0, 0};
        jc = '{0, 0};
        started = 0;
        done    = 0;
        for (int r = 0; r < 2; r++) begin
            req_valid[r]               = 1'b1;
            req_data[r*WIDTH +: WIDTH] = WIDTH'(16'h0100 * (r + 1));
            req_last[r]                = 1'b0;
        end
        for (int c = 0; c < 100 && done < 4; c++) begin
            @(negedge clock);
            acc_r = req_ready & req_valid;
            @(posedge clock);
            #1;
            for (int r = 0; r < 2; r++) begin
                if (acc_r[r]) begin
                    if (bc[r] == 0) begin
                        n_tests++;
                        assert (r === started % 2) else begin
                            n_fail++;
                            $error("FAIL grant_order: got %0d expected %0d", r, started % 2);
                        end
                        started++;
                        bc[r] = 1;
                        req_data[r*WIDTH +: WIDTH] = WIDTH'(jc[r] + 1);
                        req_last[r] = 1'b1;
                    end else begin
                        job_end(r, WIDTH'(16'h0100 * (r + 1) + jc[r] + 1));
                        jc[r]++;
                        done++;
                        bc[r] = 0;
                        req_last[r] = 1'b0;
                        if (jc[r] == 2) req_valid[r] = 1'b0;
                        else req_data[r*WIDTH +: WIDTH] = WIDTH'(16'h0100 * (r + 1));
                    end
                end
            end
        end
        n_tests++;
        assert (done === 4) else begin
            n_fail++;
            $error("FAIL alternate_jobs: got %0d jobs expected 4", done);
        end
        req_valid = '0;
        req_last  = '0;
        drain();

        // requester 0 stalls 3 cycles mid-job while requester 1 waits
        send_beat(0, 16'h0010, 1'b0, 1'b0);
        req_valid[1]               = 1'b1;
        req_data[1*WIDTH +: WIDTH] = 16'h0055;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_tests++;
            assert (req_ready === 2'b01) else begin
                n_fail++;
                $error("FAIL gap_ready: got %b expected 01", req_ready);
            end
            @(posedge clock);
            #1;
            n_tests++;
            assert ({acc_clr, acc_add_sub, acc_d} === '0) else begin
                n_fail++;
                $error("FAIL gap_add_zero: clr=%b sub=%b d=%h expected 0", acc_clr, acc_add_sub, acc_d);
            end
        end
        req_valid[1] = 1'b0;
        send_beat(0, 16'h0020, 1'b0, 1'b1);
        job_end(0, 16'h0030);
        drain();

        // reset while a job and its tag are in flight
        send_beat(0, 16'h0011, 1'b0, 1'b0);
        send_beat(0, 16'h0022, 1'b0, 1'b1);
        @(negedge clock);
        n_tests++;
        assert (busy === 1'b1) else begin
            n_fail++;
            $error("FAIL busy_in_flight: got %b expected 1", busy);
        end
        rstn = 1'b0;
        #1;
        n_tests++;
        assert ({busy, res_valid, req_ready} === '0) else begin
            n_fail++;
            $error("FAIL reset_mid_job: busy=%b rv=%b rdy=%b expected 0", busy, res_valid, req_ready);
        end
        repeat (2) @(posedge clock);
        #1 rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            n_tests++;
            assert ({res_valid, busy} === 2'b00) else begin
                n_fail++;
                $error("FAIL discarded_job: rv=%b busy=%b expected 00", res_valid, busy);
            end
        end

        // pointer back at 0 after reset: requester 0 wins a simultaneous request
        req_valid = 2'b11;
        @(negedge clock);
        @(negedge clock);
        n_tests++;
        assert (req_ready === 2'b01) else begin
            n_fail++;
            $error("FAIL ptr_after_reset: got %b expected 01", req_ready);
        end
        req_valid = '0;
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
